// File: rtl/pulse_extender.sv
// rtl/pulse_extender.sv - stretches single-cycle event strobes into pulses with guaranteed high time and low gap
`timescale 1ns/1ps
module pulse_extender #(
  parameter int LENGTH_IN_BITS = 4,
  parameter int GAP_IN_BITS    = 4,
  parameter int PENDING_BITS   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy,
  output logic overflow
);

  localparam int CW = (LENGTH_IN_BITS > GAP_IN_BITS) ? LENGTH_IN_BITS : GAP_IN_BITS;
  localparam logic [CW-1:0] HIGH_LAST = CW'((1 << LENGTH_IN_BITS) - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((1 << GAP_IN_BITS) - 1);
  localparam logic [PENDING_BITS-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic [PENDING_BITS-1:0] pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      count    <= '0;
      pending  <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        S_IDLE: begin
          count <= '0;
          if (in) begin
            state <= S_HIGH;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (count == HIGH_LAST) begin
            state <= S_GAP;
            out   <= 1'b0;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
          if (in) begin
            if (pending != PEND_MAX) pending <= pending + 1'b1;
            else                     overflow <= 1'b1;
          end
        end
        S_GAP: begin
          if (count == GAP_LAST) begin
            count <= '0;
            // An event arriving on the consuming cycle cancels the decrement.
            if (pending != '0) begin
              state <= S_HIGH;
              out   <= 1'b1;
              if (!in) pending <= pending - 1'b1;
            end else if (in) begin
              state <= S_HIGH;
              out   <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + 1'b1;
            if (in) begin
              if (pending != PEND_MAX) pending <= pending + 1'b1;
              else                     overflow <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          count   <= '0;
          pending <= '0;
          out     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  a_idle_no_pending: assert property (@(posedge clk) disable iff (!reset)
    (state == S_IDLE) |-> (pending == '0));

endmodule

// File: tb/tb_pulse_extender.sv
// tb/tb_pulse_extender.sv - scenario table, reset corner and random model comparison for pulse_extender
`timescale 1ns/1ps
module tb_pulse_extender;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_m = 1'b0, in_s = 1'b0;
  logic out_m, busy_m, ovf_m;
  logic out_s, busy_s, ovf_s;

  always #5 clk = ~clk;

  pulse_extender dut_m (
    .clk(clk), .reset(reset), .in(in_m),
    .out(out_m), .busy(busy_m), .overflow(ovf_m)
  );

  pulse_extender #(.LENGTH_IN_BITS(2), .GAP_IN_BITS(3), .PENDING_BITS(2)) dut_s (
    .clk(clk), .reset(reset), .in(in_s),
    .out(out_s), .busy(busy_s), .overflow(ovf_s)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_m = 1'b0;
    in_s = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    string name;
    int    sel;
    int    ev_lo, ev_hi, ev_extra;
    int    pulses, first, last, busy_fall, ovf_cnt, ovf_cyc, width, gmin;
  } scn_t;

  scn_t scn[6];

  int r_pulses, r_first, r_last, r_busy_fall, r_ovf_cnt, r_ovf_cyc, r_wmin, r_wmax, r_gmin;

  // Events are driven during cycle c; outputs sampled after the next edge belong to cycle c+1.
  task automatic run_scn(input int sel, input int ev_lo, input int ev_hi, input int ev_extra, input int ncyc);
    bit prev_o, prev_b, o, b, ov, v;
    int rise, fall, t;
    prev_o = 0; prev_b = 0; rise = -1; fall = -1;
    r_pulses = 0; r_first = -1; r_last = -1; r_busy_fall = -1;
    r_ovf_cnt = 0; r_ovf_cyc = -1; r_wmin = 1000000; r_wmax = 0; r_gmin = 1000000;
    for (int c = 0; c < ncyc; c++) begin
      v = ((c >= ev_lo) && (c <= ev_hi)) || (c == ev_extra);
      if (sel != 0) in_s = v; else in_m = v;
      @(posedge clk);
      #1;
      t = c + 1;
      o  = (sel != 0) ? out_s  : out_m;
      b  = (sel != 0) ? busy_s : busy_m;
      ov = (sel != 0) ? ovf_s  : ovf_m;
      if (o && !prev_o) begin
        r_pulses++;
        if (r_first < 0) r_first = t;
        r_last = t;
        rise = t;
        if (fall >= 0 && (t - fall) < r_gmin) r_gmin = t - fall;
      end
      if (!o && prev_o) begin
        if ((t - rise) < r_wmin) r_wmin = t - rise;
        if ((t - rise) > r_wmax) r_wmax = t - rise;
        fall = t;
      end
      if (!b && prev_b && r_busy_fall < 0) r_busy_fall = t;
      if (ov) begin
        r_ovf_cnt++;
        if (r_ovf_cyc < 0) r_ovf_cyc = t;
      end
      prev_o = o;
      prev_b = b;
    end
    in_m = 1'b0;
    in_s = 1'b0;
    if (r_gmin == 1000000) r_gmin = 0;
  endtask

  localparam int H = 16, G = 16, PMAX = 3;
  int m_start;
  bit m_valid;
  int m_pend;

  // Reference: a pulse is fully described by its start cycle; the window ends H+G-1 cycles later.
  function automatic void model_step(input bit v, input int t, output bit eo, output bit eb, output bit ev);
    int  last_gap;
    bit  active;
    bit  drop;
    drop = 0;
    last_gap = m_start + H + G - 1;
    active = m_valid && (t <= last_gap);
    if (!active) begin
      if (v) begin m_start = t + 1; m_valid = 1; end
    end else if (t == last_gap) begin
      if (m_pend > 0) begin
        m_start = t + 1;
        if (!v) m_pend--;
      end else if (v) begin
        m_start = t + 1;
      end
    end else if (v) begin
      if (m_pend < PMAX) m_pend++;
      else drop = 1;
    end
    eo = m_valid && (t + 1 >= m_start) && (t + 1 < m_start + H);
    eb = m_valid && (t + 1 <= m_start + H + G - 1);
    ev = drop;
  endfunction

  initial begin
    int  t, busy_seen, pulses_after, first_after, fall_after, p, quiet_hits;
    bit  eo, eb, ev, v, prev_o, prev_b;

    scn[0] = '{"single",       0, 10, 10, -1, 1, 11,  11,  43, 0, -1, 16, 0};
    scn[1] = '{"back_to_back", 0, 10, 11, -1, 2, 11,  43,  75, 0, -1, 16, 16};
    scn[2] = '{"overflow",     0, 10, 14, -1, 4, 11, 107, 139, 1, 15, 16, 16};
    scn[3] = '{"gap_end",      0, 10, 10, 42, 2, 11,  43,  75, 0, -1, 16, 16};
    scn[4] = '{"small_single", 1, 10, 10, -1, 1, 11,  11,  23, 0, -1,  4, 0};
    scn[5] = '{"small_burst",  1, 10, 12, -1, 3, 11,  35,  47, 0, -1,  4, 8};

    #2;
    check("reset_out",  int'(out_m),  0);
    check("reset_busy", int'(busy_m), 0);
    check("reset_ovf",  int'(ovf_m),  0);

    foreach (scn[i]) begin
      do_reset();
      run_scn(scn[i].sel, scn[i].ev_lo, scn[i].ev_hi, scn[i].ev_extra, 200);
      check({scn[i].name, "_pulses"},    r_pulses,    scn[i].pulses);
      check({scn[i].name, "_first"},     r_first,     scn[i].first);
      check({scn[i].name, "_last"},      r_last,      scn[i].last);
      check({scn[i].name, "_busy_fall"}, r_busy_fall, scn[i].busy_fall);
      check({scn[i].name, "_ovf_cnt"},   r_ovf_cnt,   scn[i].ovf_cnt);
      check({scn[i].name, "_ovf_cyc"},   r_ovf_cyc,   scn[i].ovf_cyc);
      check({scn[i].name, "_wmin"},      r_wmin,      scn[i].width);
      check({scn[i].name, "_wmax"},      r_wmax,      scn[i].width);
      check({scn[i].name, "_gmin"},      r_gmin,      scn[i].gmin);
    end

    // Reset mid-HIGH while an overflow pulse is showing; queued events must not replay.
    do_reset();
    pulses_after = 0; first_after = -1; fall_after = -1; prev_o = 0; prev_b = 0;
    for (int c = 0; c < 150; c++) begin
      in_m = ((c >= 10) && (c <= 14)) || (c == 30);
      if (!reset) in_m = 1'b0;
      @(posedge clk);
      #1;
      t = c + 1;
      if (t == 15) begin
        check("rst_pre_out", int'(out_m), 1);
        check("rst_pre_ovf", int'(ovf_m), 1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_out",  int'(out_m),  0);
        check("rst_async_busy", int'(busy_m), 0);
        check("rst_async_ovf",  int'(ovf_m),  0);
      end
      if (t == 20) reset = 1'b1;
      if (t > 20) begin
        if (out_m && !prev_o) begin
          pulses_after++;
          if (first_after < 0) first_after = t;
        end
        if (!busy_m && prev_b && fall_after < 0) fall_after = t;
      end
      prev_o = out_m;
      prev_b = busy_m;
    end
    in_m = 1'b0;
    check("rst_after_pulses", pulses_after, 1);
    check("rst_after_rise",   first_after,  31);
    check("rst_after_fall",   fall_after,   63);

    do_reset();
    quiet_hits = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (out_m || busy_m || ovf_m || out_s || busy_s || ovf_s) quiet_hits++;
    end
    check("quiescent", quiet_hits, 0);

    do_reset();
    m_start = 0; m_valid = 0; m_pend = 0;
    busy_seen = 0;
    for (int c = 0; c < 4000; c++) begin
      case ((c / 250) % 3)
        0: p = 3;
        1: p = 12;
        default: p = 45;
      endcase
      v = ($urandom_range(0, 99) < p);
      model_step(v, c, eo, eb, ev);
      in_m = v;
      @(posedge clk);
      #1;
      check($sformatf("rand_out@%0d", c + 1),  int'(out_m),  int'(eo));
      check($sformatf("rand_busy@%0d", c + 1), int'(busy_m), int'(eb));
      check($sformatf("rand_ovf@%0d", c + 1),  int'(ovf_m),  int'(ev));
      if (busy_m) busy_seen++;
    end
    in_m = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
